// File: rtl/morse_pkg.sv
// morse_pkg: shared timing constants for the Morse receiver blocks.
// Holds the default tick divider (1 ms at 100 MHz) and the default
// thresholds, in ticks, of the four gap/hold timers. Used by
// morse_timers and morse_rx so that both agree on the timing.
package morse_pkg;

   localparam int TICK_DIV_DEF    = 100000;
   localparam int BTN_TICKS_DEF   = 1000;
   localparam int DASH_TICKS_DEF  = 200;
   localparam int INTER_TICKS_DEF = 300;
   localparam int WORD_TICKS_DEF  = 700;

   // Width of a counter that must be able to hold the value n.
   function automatic int count_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/morse_timer.sv
// morse_timer: one sticky tick-counting timeout.
// Counts tick pulses from 0. When the count reaches THRESH the done flag
// is set, the count freezes and done stays high until res or reset.
// Ports:
//   clk_100MHz  in   system clock
//   reset       in   synchronous active-high reset
//   tick        in   one-cycle pulse per time unit
//   res         in   level; holds this timer cleared (wins over tick)
//   done        out  registered sticky timeout flag
module morse_timer
   import morse_pkg::*;
#(
   parameter int THRESH = DASH_TICKS_DEF
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic tick,
   input  logic res,
   output logic done
);

   localparam int CW = count_width(THRESH);

   if (THRESH < 1) begin : g_bad_thresh
      $error("morse_timer: THRESH must be at least 1");
   end

   logic [CW-1:0] count_reg;
   logic          done_reg;

   always_ff @(posedge clk_100MHz) begin
      if (reset || res) begin
         count_reg <= '0;
         done_reg  <= 1'b0;
      end else if (tick && !done_reg) begin
         count_reg <= count_reg + 1'b1;
         // The tick that brings the count to THRESH raises done.
         if (count_reg == CW'(THRESH - 1)) begin
            done_reg <= 1'b1;
         end
      end
   end

   assign done = done_reg;

endmodule

// File: rtl/morse_timers.sv
// morse_timers: shared 1 ms prescaler plus four sticky timeouts
// (button hold, dot/dash, inter-character gap, word gap).
// Ports:
//   clk_100MHz    in   system clock
//   reset         in   synchronous active-high reset
//   btn_to_res    in   level; holds the button-hold timer cleared
//   dash_to_res   in   level; holds the dot/dash timer cleared
//   inter_to_res  in   level; holds the inter-character gap timer cleared
//   word_to_res   in   level; holds the word gap timer cleared
//   btn_to        out  button held too long (sticky)
//   dash_to       out  press long enough to be a dash (sticky)
//   inter_to      out  character gap elapsed (sticky)
//   word_to       out  word gap elapsed (sticky)
module morse_timers
   import morse_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_DEF,
   parameter int BTN_TICKS   = BTN_TICKS_DEF,
   parameter int DASH_TICKS  = DASH_TICKS_DEF,
   parameter int INTER_TICKS = INTER_TICKS_DEF,
   parameter int WORD_TICKS  = WORD_TICKS_DEF
) (
   input  logic clk_100MHz,
   input  logic reset,
   input  logic btn_to_res,
   input  logic dash_to_res,
   input  logic inter_to_res,
   input  logic word_to_res,
   output logic btn_to,
   output logic dash_to,
   output logic inter_to,
   output logic word_to
);

   if (TICK_DIV < 2) begin : g_bad_div
      $error("morse_timers: TICK_DIV must be at least 2");
   end

   localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
   localparam int THRESHES [4] = '{BTN_TICKS, DASH_TICKS, INTER_TICKS, WORD_TICKS};

   logic [PW-1:0] presc_reg;
   logic          tick_reg;
   logic [3:0]    res_bus;
   logic [3:0]    done_bus;

   // Free-running prescaler; tick is registered so it follows the wrap
   // state by one edge and lasts exactly one cycle.
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         presc_reg <= '0;
         tick_reg  <= 1'b0;
      end else begin
         tick_reg <= (presc_reg == PW'(TICK_DIV - 1));
         if (presc_reg == PW'(TICK_DIV - 1)) begin
            presc_reg <= '0;
         end else begin
            presc_reg <= presc_reg + 1'b1;
         end
      end
   end

   assign res_bus = {word_to_res, inter_to_res, dash_to_res, btn_to_res};

   for (genvar gi = 0; gi < 4; gi++) begin : g_timer
      morse_timer #(
         .THRESH (THRESHES[gi])
      ) u_timer (
         .clk_100MHz (clk_100MHz),
         .reset      (reset),
         .tick       (tick_reg),
         .res        (res_bus[gi]),
         .done       (done_bus[gi])
      );
   end

   assign btn_to   = done_bus[0];
   assign dash_to  = done_bus[1];
   assign inter_to = done_bus[2];
   assign word_to  = done_bus[3];

endmodule

// File: tb/tb_morse_timers.sv
// tb_morse_timers: scoreboard bench for morse_timers with a small tick
// divider. A reference model advances on every clock edge from the
// sampled inputs and queues the expected outputs; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_morse_timers;

   localparam int TD = 4;
   localparam int TH [4] = '{10, 3, 4, 8};   // btn, dash, inter, word

   logic clk_100MHz = 1'b0;
   logic reset = 1'b1;
   logic btn_to_res = 1'b0, dash_to_res = 1'b0, inter_to_res = 1'b0, word_to_res = 1'b0;
   logic btn_to, dash_to, inter_to, word_to;

   always #5 clk_100MHz = ~clk_100MHz;

   morse_timers #(
      .TICK_DIV    (TD),
      .BTN_TICKS   (TH[0]),
      .DASH_TICKS  (TH[1]),
      .INTER_TICKS (TH[2]),
      .WORD_TICKS  (TH[3])
   ) dut (
      .clk_100MHz   (clk_100MHz),
      .reset        (reset),
      .btn_to_res   (btn_to_res),
      .dash_to_res  (dash_to_res),
      .inter_to_res (inter_to_res),
      .word_to_res  (word_to_res),
      .btn_to       (btn_to),
      .dash_to      (dash_to),
      .inter_to     (inter_to),
      .word_to      (word_to)
   );

   typedef struct {
      logic [3:0] exp;
      int         edge_no;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // ---------------- reference model ----------------
   // Edge numbers restart at 0 on each edge that samples reset high.
   // A tick is visible during the cycle after every edge whose number
   // is a positive multiple of TD; each timer counts ticks since its
   // last clear and saturates at its threshold.
   bit model_on = 1'b0;
   int e_since = 0;
   bit tick_pend = 1'b0;
   int ticks [4];

   always @(posedge clk_100MHz) begin
      logic [3:0] r;
      bit tick_now;
      exp_t item;
      r = {word_to_res, inter_to_res, dash_to_res, btn_to_res};
      if (reset) begin
         model_on  = 1'b1;
         e_since   = 0;
         tick_pend = 1'b0;
         for (int i = 0; i < 4; i++) ticks[i] = 0;
      end else if (model_on) begin
         e_since++;
         tick_now  = tick_pend;
         tick_pend = (e_since % TD == 0);
         for (int i = 0; i < 4; i++) begin
            if (r[i]) ticks[i] = 0;
            else if (tick_now && ticks[i] < TH[i]) ticks[i]++;
         end
      end
      if (model_on) begin
         for (int i = 0; i < 4; i++) item.exp[i] = (ticks[i] >= TH[i]);
         item.edge_no = e_since;
         exp_q.push_back(item);
      end
   end

   // ---------------- monitor ----------------
   int  rise [4];
   logic [3:0] prev_act = 4'b0;

   always @(negedge clk_100MHz) begin
      exp_t item;
      logic [3:0] act;
      act = {word_to, inter_to, dash_to, btn_to};
      if (exp_q.size() > 0) begin
         item = exp_q.pop_front();
         vectors++;
         if (act !== item.exp) begin
            miscompares++;
            $display("FAIL outputs edge %0d: got {word,inter,dash,btn}=%b, expected %b",
                     item.edge_no, act, item.exp);
         end else begin
            $display("vec edge %0d outputs=%b ok", item.edge_no, act);
         end
         for (int i = 0; i < 4; i++) begin
            if (act[i] === 1'b1 && prev_act[i] !== 1'b1) rise[i] = item.edge_no;
         end
         prev_act = act;
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk_100MHz);
   endtask

   task automatic check_edge(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: rose at edge %0d, expected edge %0d", name, got, want);
      end else begin
         $display("chk %s rose at edge %0d ok", name, got);
      end
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1;
      wait_neg(cycles);
      reset = 1'b0;          // last reset-high edge is edge 0
      for (int i = 0; i < 4; i++) rise[i] = -1;
   endtask

   initial begin
      // Timeline: all *_res low, thresholds reached at fixed edges.
      wait_neg(1);
      do_reset(3);
      wait_neg(45);
      check_edge("dash_rise",  rise[1], 13);
      check_edge("inter_rise", rise[2], 17);
      check_edge("word_rise",  rise[3], 33);
      check_edge("btn_rise",   rise[0], 41);

      // inter_to_res one-cycle pulse at edge 10.
      do_reset(2);
      wait_neg(9);  inter_to_res = 1'b1;
      wait_neg(1);  inter_to_res = 1'b0;
      wait_neg(35);

      // dash_to_res high exactly at edge 13 (coincides with a tick).
      do_reset(2);
      wait_neg(12); dash_to_res = 1'b1;
      wait_neg(1);  dash_to_res = 1'b0;
      wait_neg(25);

      // dash_to already high, one-cycle clear at edge 20.
      do_reset(2);
      wait_neg(19); dash_to_res = 1'b1;
      wait_neg(1);  dash_to_res = 1'b0;
      wait_neg(20);

      // Reset pulse at edge 15 discards progress; dash re-rises at +13.
      do_reset(2);
      wait_neg(14);
      do_reset(1);
      wait_neg(20);
      check_edge("dash_rise_after_reset", rise[1], 13);

      // Random res activity with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         btn_to_res   = ($urandom_range(0, 99) < 2);
         dash_to_res  = ($urandom_range(0, 99) < 4);
         inter_to_res = ($urandom_range(0, 99) < 3);
         word_to_res  = ($urandom_range(0, 99) < 2);
         reset        = ($urandom_range(0, 999) < 3);
         wait_neg(1);
      end
      reset = 1'b0;
      {btn_to_res, dash_to_res, inter_to_res, word_to_res} = 4'b0;
      wait_neg(3);
      vectors++;
      if (exp_q.size() > 1) begin
         miscompares++;
         $display("FAIL queue_drain: %0d left, expected at most 1", exp_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
